// File: rtl/ssd_scanner_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package ssd_scanner_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/ssd_scanner_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module ssd_scanner_hex7seg
    import ssd_scanner_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_OFF;
        case (value)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
            default: segments = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scanner.sv
// Time-multiplexed four-digit seven-segment scanner; each digit is latched once per slot.
// Define SSD_GHOST_BLANK_EN to hold the anodes off for BLANK_CYCLES at the start of each slot.
module ssd_scanner
    import ssd_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digit0_en_i,
    input  logic       digit1_en_i,
    input  logic       digit2_en_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
`ifdef SSD_GHOST_BLANK_EN
    localparam logic [CNT_W-1:0] LOAD_AT = CNT_W'(BLANK_CYCLES);
`else
    // BLANK_CYCLES has no effect here: the load happens on the first cycle of the slot.
    localparam logic [CNT_W-1:0] LOAD_AT = CNT_W'(0 * BLANK_CYCLES);
`endif

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic             cur_en;
    logic [3:0]       cur_val;
    logic [6:0]       cur_seg;
    logic [3:0]       onehot;

    always_comb begin
        cur_en  = 1'b0;
        cur_val = 4'h0;
        case (idx)
            2'd0: begin cur_en = digit0_en_i; cur_val = digit0_i; end
            2'd1: begin cur_en = digit1_en_i; cur_val = digit1_i; end
            2'd2: begin cur_en = digit2_en_i; cur_val = digit2_i; end
            2'd3: begin cur_en = digit3_en_i; cur_val = digit3_i; end
            default: begin cur_en = 1'b0; cur_val = 4'h0; end
        endcase
    end

    assign onehot = 4'(4'b0001 << idx);

    ssd_scanner_hex7seg u_hex7seg (
        .value    (cur_val),
        .segments (cur_seg)
    );

    // LOAD_AT never equals CNT_MAX, so the slot-end blanking and the load never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt        <= '0;
            idx        <= '0;
            anode_o    <= ANODE_OFF;
            segments_o <= SEG_OFF;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt        <= '0;
                idx        <= idx + 2'd1;
                anode_o    <= ANODE_OFF;
                segments_o <= SEG_OFF;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == LOAD_AT) begin
                anode_o    <= ~(onehot & {4{cur_en}});
                segments_o <= cur_en ? cur_seg : SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scanner.sv
// Self-checking bench for ssd_scanner: directed scenarios plus random traffic against a slot/time model.
module tb_ssd_scanner;

    localparam int RD = 8;
    localparam int BC = 2;
`ifdef SSD_GHOST_BLANK_EN
    localparam int LP = BC;
`else
    localparam int LP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] en = 4'hF;
    logic [3:0] v0 = 4'h8, v1 = 4'h8, v2 = 4'h8, v3 = 4'h8;
    logic [3:0] anode_o;
    logic [6:0] segments_o;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int         total = 0;
    int         bad = 0;
    int         t = 0;
    bit         was_reset = 1'b1;
    bit         snap_en = 1'b0;
    logic [3:0] snap_val = 4'h0;
    logic [3:0] exp_a;
    logic [6:0] exp_s;

    ssd_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .digit0_en_i (en[0]),
        .digit1_en_i (en[1]),
        .digit2_en_i (en[2]),
        .digit3_en_i (en[3]),
        .digit0_i    (v0),
        .digit1_i    (v1),
        .digit2_i    (v2),
        .digit3_i    (v3),
        .anode_o     (anode_o),
        .segments_o  (segments_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] val_of(input int k);
        case (k)
            0: return v0;
            1: return v1;
            2: return v2;
            default: return v3;
        endcase
    endfunction

    // Advance one clock: t counts edges since reset release; slot k's digit is
    // latched on the edge whose pre-edge offset within the slot equals LP.
    task automatic tick();
        int tp;
        tp = t;
        if (!rst_n) begin
            was_reset = 1'b1;
            t = 0;
        end else begin
            was_reset = 1'b0;
            if ((tp % RD) == LP) begin
                snap_en  = en[(tp / RD) % 4];
                snap_val = val_of((tp / RD) % 4);
            end
            t = tp + 1;
        end
        @(posedge clk);
        #1;
        exp_a = 4'hF;
        exp_s = 7'h7F;
        if (!was_reset && ((t % RD) > LP) && snap_en) begin
            exp_a = ~(4'b0001 << ((t / RD) % 4));
            exp_s = seg_tab[snap_val];
        end
        total++;
        assert (anode_o === exp_a) else begin
            bad++;
            $error("FAIL anode t=%0d got=%b exp=%b", t, anode_o, exp_a);
        end
        total++;
        assert (segments_o === exp_s) else begin
            bad++;
            $error("FAIL segments t=%0d got=%b exp=%b", t, segments_o, exp_s);
        end
        total++;
        assert ($countones(~anode_o) <= 1) else begin
            bad++;
            $error("FAIL onehot t=%0d got=%b exp=at most one low", t, anode_o);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with all digits showing 8, then release and scan.
        en = 4'hF; v0 = 4'h8; v1 = 4'h8; v2 = 4'h8; v3 = 4'h8;
        do_reset(5);
        run(2 * RD);

        // Scan order with digit k showing value k.
        do_reset(1);
        v0 = 4'h0; v1 = 4'h1; v2 = 4'h2; v3 = 4'h3;
        run(4 * RD);

        // Digit 2 disabled: its slot stays dark, others keep their schedule.
        en = 4'b1011;
        run(8 * RD);
        en = 4'hF;

        // Mid-slot value change on digit 0: A until the slot ends, F next time round.
        v0 = 4'hA;
        do_reset(1);
        run(3);
        v0 = 4'hF;
        run(5 * RD);

        // Reset asserted in the middle of slot 2, then scanning restarts at digit 0.
        do_reset(1);
        run(2 * RD + 3);
        do_reset(2);
        run(2 * RD);

        // Random traffic: inputs change at arbitrary cycles, occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) v0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) v1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) v2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) v3 = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        run(4 * RD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
